parking_occupancy_ctrl: RTL

Parametrised multi-slot successor to the single-bay parking FSM. Tracks lot occupancy from Entry and Exit sensor levels. Drives an entry gate for a fixed number of cycles and asserts Lock when the lot is full. Scans the free-slot count, in decimal, across a multi-digit seven-segment display. Sits behind the existing clock divider and runs entirely in the NewCLK domain.

---
 rtl/park_pkg.sv | 22 ++
 rtl/bcd_digit_updown.sv | 33 +++
 rtl/parking_occupancy_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// Shared types and constants for the parking occupancy controller:
// state encoding, BCD digit type, seven-segment table and alarm length.
package park_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GATE_IN = 2'b01,
        FULL    = 2'b10
    } park_state_t;

    typedef logic [3:0] bcd_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}, indexed by BCD value
    localparam logic [6:0] SEG7_LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    localparam int ALARM_CYCLES = 8;

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit up/down counter; carry/borrow outputs are combinational so
// a chain of these ripples a full multi-digit increment or decrement in one edge.
module bcd_digit_updown
    import park_pkg::*;
#(
    parameter bcd_t RESET_VAL = 4'd0
) (
    input  logic NewCLK,
    input  logic RST,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_carry,
    output logic o_borrow,
    output bcd_t o_digit
);

    bcd_t r_digit;

    assign o_carry  = i_inc & (r_digit == 4'd9);
    assign o_borrow = i_dec & (r_digit == 4'd0);
    assign o_digit  = r_digit;

    always_ff @(posedge NewCLK) begin
        if (!RST) begin
            r_digit <= RESET_VAL;
        end else if (i_inc) begin
            r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        end else if (i_dec) begin
            r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-slot parking controller: occupancy count, timed entry gate, full lock and
// scanned BCD free-slot display. Define PARK_ALARM_EN to add the rejected-entry Alarm.
module parking_occupancy_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY    = 6,
    parameter int CNT_W       = 3,
    parameter int NUM_DIGITS  = 3,
    parameter int GATE_CYCLES = 4,
    parameter int GATE_W      = 3
) (
    input  logic                  NewCLK,
    input  logic                  RST,
    input  logic                  Entry,
    input  logic                  Exit,
    output logic                  Lock,
    output logic                  Gate,
    output logic [CNT_W-1:0]      Count,
    output logic [6:0]            Seg_State,
    output logic [NUM_DIGITS-1:0] Seg_En
`ifdef PARK_ALARM_EN
    ,
    output logic                  Alarm
`endif
);

    localparam logic [CNT_W-1:0]      CAP_C       = CNT_W'(CAPACITY);
    localparam logic [GATE_W-1:0]     GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] SEG_EN_INIT = ~NUM_DIGITS'(1);

    park_state_t            r_state;
    logic [CNT_W-1:0]       r_count;
    logic [GATE_W-1:0]      r_timer;
    logic                   r_gate, r_lock;
    logic                   r_entry_d, r_exit_d, r_entry_p, r_exit_p;
    logic [NUM_DIGITS-1:0]  r_seg_en;
    logic                   w_cnt_inc, w_cnt_dec;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_next_full;
    bcd_t                   w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  w_carry, w_borrow;
    logic                   w_unused_ovf;
    bcd_t                   w_sel_digit;

    // Edge pulses are registered, so a rise sampled at edge k acts at edge k+1
    always_ff @(posedge NewCLK) begin
        if (!RST) begin
            r_entry_d <= 1'b0;
            r_exit_d  <= 1'b0;
            r_entry_p <= 1'b0;
            r_exit_p  <= 1'b0;
        end else begin
            r_entry_d <= Entry;
            r_exit_d  <= Exit;
            r_entry_p <= Entry & ~r_entry_d;
            r_exit_p  <= Exit & ~r_exit_d;
        end
    end

    always_comb begin
        w_cnt_inc = 1'b0;
        w_cnt_dec = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_inc = r_entry_p & ~r_exit_p & (r_count < CAP_C);
                w_cnt_dec = r_exit_p & ~r_entry_p & (r_count != '0);
            end
            GATE_IN: w_cnt_dec = r_exit_p & (r_count != '0);
            FULL:    w_cnt_dec = r_exit_p & ~r_entry_p & (r_count != '0);
            default: ;
        endcase
    end

    assign w_count_next = w_cnt_inc ? r_count + 1'b1 :
                          w_cnt_dec ? r_count - 1'b1 : r_count;
    assign w_next_full  = (w_count_next == CAP_C);

    always_ff @(posedge NewCLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_count <= '0;
            r_timer <= '0;
            r_gate  <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            case (r_state)
                IDLE: begin
                    if (r_entry_p) begin
                        r_state <= GATE_IN;
                        r_timer <= GATE_LOAD;
                        r_gate  <= 1'b1;
                        r_lock  <= w_next_full;
                    end else begin
                        r_gate <= 1'b0;
                        r_lock <= 1'b0;
                    end
                end
                GATE_IN: begin
                    if (r_timer == '0) begin
                        r_state <= w_next_full ? FULL : IDLE;
                        r_gate  <= 1'b0;
                        r_lock  <= w_next_full;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        r_gate  <= 1'b1;
                        r_lock  <= w_next_full;
                    end
                end
                FULL: begin
                    // Simultaneous entry+exit swaps cars: open the gate, come back to FULL
                    if (r_entry_p && r_exit_p) begin
                        r_state <= GATE_IN;
                        r_timer <= GATE_LOAD;
                        r_gate  <= 1'b1;
                        r_lock  <= w_next_full;
                    end else if (r_exit_p) begin
                        r_state <= IDLE;
                        r_gate  <= 1'b0;
                        r_lock  <= 1'b0;
                    end else begin
                        r_gate <= 1'b0;
                        r_lock <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gate  <= 1'b0;
                    r_lock  <= 1'b0;
                end
            endcase
        end
    end

    assign Count = r_count;
    assign Gate  = r_gate;
    assign Lock  = r_lock;

    // Free slots = CAPACITY - Count, so an occupancy increment decrements the BCD chain
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam int DIGIT_RST = (CAPACITY / (10 ** gi)) % 10;
        logic w_inc, w_dec;
        if (gi == 0) begin : g_lsd
            assign w_inc = w_cnt_dec;
            assign w_dec = w_cnt_inc;
        end else begin : g_chain
            assign w_inc = w_carry[gi-1];
            assign w_dec = w_borrow[gi-1];
        end
        bcd_digit_updown #(.RESET_VAL(bcd_t'(DIGIT_RST))) u_digit (
            .NewCLK  (NewCLK),
            .RST     (RST),
            .i_inc   (w_inc),
            .i_dec   (w_dec),
            .o_carry (w_carry[gi]),
            .o_borrow(w_borrow[gi]),
            .o_digit (w_digit[gi])
        );
    end

    assign w_unused_ovf = w_carry[NUM_DIGITS-1] ^ w_borrow[NUM_DIGITS-1];

    always_ff @(posedge NewCLK) begin
        if (!RST) begin
            r_seg_en <= SEG_EN_INIT;
        end else if ($onehot(~r_seg_en)) begin
            r_seg_en <= (r_seg_en << 1) | (r_seg_en >> (NUM_DIGITS - 1));
        end else begin
            r_seg_en <= SEG_EN_INIT;
        end
    end

    always_comb begin
        w_sel_digit = w_digit[0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_seg_en[i]) w_sel_digit = w_digit[i];
        end
        Seg_State = (w_sel_digit <= 4'd9) ? SEG7_LUT[w_sel_digit] : SEG7_BLANK;
    end

    assign Seg_En = r_seg_en;

`ifdef PARK_ALARM_EN
    logic [3:0] r_alarm_cnt;

    always_ff @(posedge NewCLK) begin
        if (!RST) begin
            r_alarm_cnt <= '0;
        end else if (r_state == FULL && r_entry_p && !r_exit_p) begin
            r_alarm_cnt <= 4'(ALARM_CYCLES);
        end else if (r_alarm_cnt != '0) begin
            r_alarm_cnt <= r_alarm_cnt - 1'b1;
        end
    end

    assign Alarm = (r_alarm_cnt != '0);
`endif

endmodule
